frame_fetch_ctrl: RTL
=====================

# frame_fetch_ctrl

Memory-side initiator for the RGB→YUV simulation datapath. Walks a frame stored in the planar pixel memory, issuing combinational reads (mem_addr/mem_read) and presenting packed RGB pixels on a valid/ready stream to the converter. It also takes the converter's YUV output and issues the registered write strobes (mem_write, y/u/v_data) back toward memory. It reports frame completion once every fetched pixel has been written back.

## Interface
- H_ACT, 1280: active pixels per line.
- V_ACT, 720: active lines per frame.
- PLANE_STRIDE, 1280: byte offset between the R, G and B planes of a line. Line stride = 3*PLANE_STRIDE.
- H_GAP, 0: idle cycles inserted after each line's last read. 0 means no gap.
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle frame start. Honoured only in IDLE.
- base_addr  in  32  frame base address, sampled on accepted start.
- mem_addr  out  32  read address.
- mem_read  out  1  read strobe.
- mem_q  in  24  {R,G,B}, valid combinationally in the same cycle as mem_read.
- pix_valid / pix_ready  out / in  1 / 1  RGB stream handshake.
- pix_data  out  24  {R,G,B}.
- pix_sof, pix_eol, pix_eof  out  1 each  first pixel of frame; last pixel of line; last pixel of frame.
- yuv_valid  in  1  converter output strobe.
- yuv_y, yuv_u, yuv_v  in  8 each  converter output.
- mem_write  out  1  write strobe.
- y_data, u_data, v_data  out  8 each  write data.
- busy  out  1  high from the cycle after an accepted start until done.
- frame_done  out  1  one-cycle completion pulse.
- err_overrun  out  1  sticky flag: a yuv_valid arrived with no outstanding pixel. Cleared by rst or an accepted start.

## Operation
- FSM states: IDLE, FETCH, HGAP, DRAIN, DONE.
- IDLE: on start, latch base_addr, clear x/y/row_base/wr_cnt/err_overrun, go to FETCH.
- FETCH: assert mem_read when skid occupancy < 2, or when occupancy = 2 and a pop occurs this cycle.
  - mem_addr = base_addr + row_base + x, where row_base = y*3*PLANE_STRIDE, accumulated by addition with no multiplier.
  - mem_q and its tags (sof/eol/eof) are pushed into the skid buffer in the same cycle as the read.
- x increments per read. At x = H_ACT-1: x←0, y++, row_base += 3*PLANE_STRIDE.
  - Go to HGAP if H_GAP > 0 and the line is not the last.
  - Go to DRAIN after the final read (x = H_ACT-1, y = V_ACT-1).
- HGAP: count H_GAP cycles with no reads, then return to FETCH. The stream continues to drain during the gap.
- DRAIN: wait until the skid buffer is empty and wr_cnt = H_ACT*V_ACT, then go to DONE.
- DONE: pulse frame_done for one cycle, deassert busy, go to IDLE.
- Write side, active in any state:
  - On yuv_valid with wr_cnt < H_ACT*V_ACT: register mem_write=1 and the y/u/v data; wr_cnt++.
  - On yuv_valid with wr_cnt = H_ACT*V_ACT, or in IDLE: no mem_write; set err_overrun.
- start outside IDLE is ignored.

## Timing
- Reset values: all outputs 0 (mem_addr, pix_data, y/u/v_data included). FSM in IDLE, counters 0, skid buffer empty.
- Latency:
  - start at cycle 0 → first mem_read at cycle 1 → pix_valid with pix_sof at cycle 2.
  - yuv_valid at cycle n → mem_write at cycle n+1.
- Throughput: with pix_ready held high, one read and one pixel per cycle, apart from HGAP cycles.
- With pix_ready low, at most 2 reads are issued ahead, then mem_read drops. pix_data stays stable while pix_valid && !pix_ready.
- Pixel-count boundaries:
  - H_ACT*V_ACT = 1: sof, eol and eof all set on one pixel.
  - V_ACT = 1: eol and eof coincide on the final pixel.
- rst mid-frame: immediate return to reset values. No frame_done pulse. The stream is dropped without completing.
- A yuv_valid in the same cycle as the DRAIN→DONE check is counted before the check.

## Structure
- Shared package rgb_yuv_pkg holds the state enum (IDLE/FETCH/HGAP/DRAIN/DONE), the default H_ACT/V_ACT/PLANE_STRIDE constants, and the 24-bit RGB pixel typedef.
- Sub-module pix_skid_buf: 2-entry buffer, 27-bit payload (24-bit data + sof/eol/eof). Provides push/pop/count and a registered output.

## Test plan
- H_ACT=4, V_ACT=2, PLANE_STRIDE=4, H_GAP=0, base_addr=0x100, pix_ready=1 → mem_addr sequence 0x100–0x103, then 0x10C–0x10F. pix_eol on the 4th and 8th pixel, pix_eof on the 8th. Converter loops back 1 cycle later → frame_done 1 cycle after the last mem_write.
- Same config, pix_ready low for cycles 2–10 → exactly 2 reads issued, then mem_read low. pix_data held constant. Stream resumes in order with no lost or duplicated pixels.
- H_GAP=3 → exactly 3 cycles without mem_read between the 4th and 5th reads. No gap after the final line.
- H_ACT=1, V_ACT=1 → a single pixel with sof, eol and eof all set. frame_done once one yuv_valid is returned.
- Extra yuv_valid after the 8th write → no mem_write, err_overrun=1. A new start clears err_overrun.
- rst asserted at pixel 5, start pulsed during FETCH → the start is ignored. After reset, all outputs are 0, with no frame_done.

Source files
------------

// File: rtl/rgb_yuv_pkg.sv
// Shared types and default frame geometry for the RGB->YUV datapath.
package rgb_yuv_pkg;

   localparam int unsigned DEF_H_ACT        = 1280;
   localparam int unsigned DEF_V_ACT        = 720;
   localparam int unsigned DEF_PLANE_STRIDE = 1280;

   typedef logic [23:0] rgb_pix_t;

   // One stream beat: pixel plus its frame-position tags (27 bits).
   typedef struct packed {
      rgb_pix_t data;
      logic     sof;
      logic     eol;
      logic     eof;
   } pix_beat_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HGAP,
      DRAIN,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry FIFO between the combinational memory read and the pixel stream.
// The head entry is held in a register, so the stream data stays stable
// while the consumer stalls.
module pix_skid_buf
   import rgb_yuv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  pix_beat_t  push_beat,
   input  logic       pop,
   output logic [1:0] count,
   output pix_beat_t  head
);

   pix_beat_t ent [2];
   logic      wr_ptr;
   logic      rd_ptr;

   // Storage, pointers and occupancy; a push into a full buffer is only
   // issued together with a pop, so the overwritten slot is the one leaving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent[0] <= '0;
         ent[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            ent[wr_ptr] <= push_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = ent[rd_ptr];

endmodule

// File: rtl/frame_fetch_ctrl.sv
// Frame fetch controller: walks the planar frame, streams RGB pixels to the
// converter and registers the converter's YUV results as memory writes.
module frame_fetch_ctrl
   import rgb_yuv_pkg::*;
#(
   parameter int unsigned H_ACT        = DEF_H_ACT,
   parameter int unsigned V_ACT        = DEF_V_ACT,
   parameter int unsigned PLANE_STRIDE = DEF_PLANE_STRIDE,
   parameter int unsigned H_GAP        = 0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   input  logic [23:0] mem_q,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [23:0] pix_data,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_eof,
   input  logic        yuv_valid,
   input  logic [7:0]  yuv_y,
   input  logic [7:0]  yuv_u,
   input  logic [7:0]  yuv_v,
   output logic        mem_write,
   output logic [7:0]  y_data,
   output logic [7:0]  u_data,
   output logic [7:0]  v_data,
   output logic        busy,
   output logic        frame_done,
   output logic        err_overrun
);

   localparam int unsigned XW          = (H_ACT > 1) ? $clog2(H_ACT) : 1;
   localparam int unsigned YW          = (V_ACT > 1) ? $clog2(V_ACT) : 1;
   localparam int unsigned GW          = (H_GAP > 1) ? $clog2(H_GAP) : 1;
   localparam int unsigned TOTAL       = H_ACT * V_ACT;
   localparam int unsigned LINE_STRIDE = 3 * PLANE_STRIDE;
   localparam logic [XW-1:0] X_LAST    = XW'(H_ACT - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(V_ACT - 1);
   localparam logic [GW-1:0] G_LAST    = GW'(H_GAP - 1);

   fetch_state_t  state, state_nxt;
   logic [31:0]   base_q, base_nxt;
   logic [31:0]   row_q, row_nxt;
   logic [XW-1:0] x_q, x_nxt;
   logic [YW-1:0] y_q, y_nxt;
   logic [GW-1:0] gap_q, gap_nxt;
   logic [31:0]   wr_cnt_q, wr_cnt_nxt;
   logic          rd_en;
   logic          pop;
   logic          start_acc;
   logic          wr_accept;
   logic          overrun;
   logic [1:0]    skid_cnt;
   pix_beat_t     push_beat;
   pix_beat_t     head;

   pix_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_en),
      .push_beat (push_beat),
      .pop       (pop),
      .count     (skid_cnt),
      .head      (head)
   );

   assign pix_valid = (skid_cnt != 2'd0);
   assign pop       = pix_valid && pix_ready;
   assign pix_data  = head.data;
   assign pix_sof   = pix_valid && head.sof;
   assign pix_eol   = pix_valid && head.eol;
   assign pix_eof   = pix_valid && head.eof;
   assign start_acc = (state == IDLE) && start;
   assign busy      = (state inside {FETCH, HGAP, DRAIN});

   // Write-side acceptance; the count is updated before the drain check sees it.
   always_comb begin
      wr_accept  = yuv_valid && (state != IDLE) && (wr_cnt_q < TOTAL);
      overrun    = yuv_valid && !wr_accept;
      wr_cnt_nxt = wr_accept ? wr_cnt_q + 32'd1 : wr_cnt_q;
   end

   // Next-state, read issue and frame-walk counters.
   always_comb begin
      state_nxt = state;
      base_nxt  = base_q;
      row_nxt   = row_q;
      x_nxt     = x_q;
      y_nxt     = y_q;
      gap_nxt   = gap_q;
      rd_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               base_nxt  = base_addr;
               row_nxt   = '0;
               x_nxt     = '0;
               y_nxt     = '0;
               gap_nxt   = '0;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            rd_en = (skid_cnt < 2'd2) || pop;
            if (rd_en) begin
               if (x_q == X_LAST) begin
                  x_nxt   = '0;
                  y_nxt   = y_q + 1'b1;
                  row_nxt = row_q + LINE_STRIDE;
                  gap_nxt = '0;
                  if (y_q == Y_LAST) begin
                     state_nxt = DRAIN;
                  end else if (H_GAP > 0) begin
                     state_nxt = HGAP;
                  end
               end else begin
                  x_nxt = x_q + 1'b1;
               end
            end
         end
         HGAP: begin
            if (gap_q == G_LAST) begin
               state_nxt = FETCH;
            end else begin
               gap_nxt = gap_q + 1'b1;
            end
         end
         DRAIN: begin
            if ((skid_cnt == 2'd0) && (wr_cnt_nxt == TOTAL)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Read port and the beat pushed alongside each read.
   always_comb begin
      mem_read       = rd_en;
      mem_addr       = rd_en ? (base_q + row_q + 32'(x_q)) : '0;
      push_beat.data = mem_q;
      push_beat.sof  = (x_q == '0) && (y_q == '0);
      push_beat.eol  = (x_q == X_LAST);
      push_beat.eof  = (x_q == X_LAST) && (y_q == Y_LAST);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame-walk registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q <= '0;
         row_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
         gap_q  <= '0;
      end else begin
         base_q <= base_nxt;
         row_q  <= row_nxt;
         x_q    <= x_nxt;
         y_q    <= y_nxt;
         gap_q  <= gap_nxt;
      end
   end

   // Registered write strobe, write count, overrun flag and completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_write   <= 1'b0;
         y_data      <= '0;
         u_data      <= '0;
         v_data      <= '0;
         wr_cnt_q    <= '0;
         err_overrun <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         mem_write  <= wr_accept;
         frame_done <= (state == DONE);
         if (wr_accept) begin
            y_data <= yuv_y;
            u_data <= yuv_u;
            v_data <= yuv_v;
         end
         if (start_acc) begin
            wr_cnt_q    <= '0;
            err_overrun <= 1'b0;
         end else begin
            wr_cnt_q <= wr_cnt_nxt;
            if (overrun) begin
               err_overrun <= 1'b1;
            end
         end
      end
   end

endmodule
